cic_i_scaler: RTL and testbench

Output conditioning stage placed directly downstream of the CIC interpolator. It takes the interpolator's full-precision integrator output and removes the CIC gain with a rounding arithmetic right shift. It then saturates the result to the DAC/consumer word width and buffers samples in a small FIFO behind a valid/ready handshake. It also reports sticky saturation and drop flags for status registers.

---
 rtl/cic_i_scaler.sv | 137 +++++++++++++
 tb/tb_cic_i_scaler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_i_scaler.sv
// cic_i_scaler: removes the CIC gain from the interpolator output with a
// rounding arithmetic right shift, saturates to the consumer word width and
// buffers samples in a show-ahead FIFO behind a valid/ready handshake.
// Sticky saturation and drop flags are kept for status registers.
module cic_i_scaler #(
    parameter int unsigned iw    = 14,
    parameter int unsigned ow    = 8,
    parameter int unsigned shift = 6,
    parameter int unsigned depth = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_dv,
    input  logic signed [iw-1:0]         data_in,
    input  logic                         clr_flags,
    input  logic                         out_ready,
    output logic signed [ow-1:0]         data_out,
    output logic                         out_valid,
    output logic [$clog2(depth+1)-1:0]   level,
    output logic                         sat_flag,
    output logic                         drop_flag
);

    localparam int unsigned aw      = $clog2(depth);
    localparam int unsigned lw      = $clog2(depth + 1);
    localparam int unsigned rnd_pos = (shift > 0) ? shift - 1 : 0;

    // Half-LSB of the post-shift result, added before the shift for round-half-up.
    localparam logic signed [iw:0] rnd   = (shift > 0) ? ((iw + 1)'(1) << rnd_pos) : '0;
    // Clip limits expressed at the pre-clip width; min is the two's complement of max+1.
    localparam logic signed [iw:0] q_max = (iw + 1)'((64'(1) << (ow - 1)) - 64'(1));
    localparam logic signed [iw:0] q_min = ~q_max;

    logic                  v1;
    logic signed [iw:0]    r1;
    logic                  v2;
    logic                  c2;
    logic signed [ow-1:0]  s2;

    logic signed [iw:0]    q_c;
    logic                  clip_c;
    logic signed [ow-1:0]  sat_val_c;

    logic signed [ow-1:0]  mem [depth];
    logic [aw-1:0]         wr_ptr;
    logic [aw-1:0]         rd_ptr;

    logic                  full_c;
    logic                  pop_c;
    logic                  push_ok_c;
    logic                  drop_c;

    // Stage 1: sign-extend by one bit and add the rounding offset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            r1 <= '0;
        end else begin
            v1 <= in_dv;
            r1 <= {data_in[iw-1], data_in} + rnd;
        end
    end

    // Shift and clip the stage-1 value to the output range.
    always_comb begin
        q_c       = r1 >>> shift;
        clip_c    = 1'b0;
        sat_val_c = q_c[ow-1:0];
        if (q_c > q_max) begin
            clip_c    = 1'b1;
            sat_val_c = q_max[ow-1:0];
        end else if (q_c < q_min) begin
            clip_c    = 1'b1;
            sat_val_c = q_min[ow-1:0];
        end
    end

    // Stage 2: register the clipped sample and its clip indication.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v2 <= 1'b0;
            c2 <= 1'b0;
            s2 <= '0;
        end else begin
            v2 <= v1;
            c2 <= clip_c & v1;
            s2 <= sat_val_c;
        end
    end

    // FIFO control: a push into a full FIFO succeeds only when a pop frees a slot.
    always_comb begin
        full_c    = (level == lw'(depth));
        pop_c     = out_valid & out_ready;
        push_ok_c = v2 & (~full_c | pop_c);
        drop_c    = v2 & full_c & ~pop_c;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(depth); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= s2;
                wr_ptr      <= wr_ptr + aw'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            level <= level + lw'(push_ok_c) - lw'(pop_c);
        end
    end

    // Sticky status flags; a set event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            sat_flag  <= c2 | (sat_flag & ~clr_flags);
            drop_flag <= drop_c | (drop_flag & ~clr_flags);
        end
    end

    // Show-ahead head of FIFO and valid derived from the registered level.
    always_comb begin
        data_out  = mem[rd_ptr];
        out_valid = (level != '0);
    end

endmodule

// File: tb/tb_cic_i_scaler.sv
// Testbench for cic_i_scaler: directed table, hand-written corner sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_cic_i_scaler;

    localparam int IW    = 14;
    localparam int OW    = 8;
    localparam int SHIFT = 6;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_dv = 1'b0;
    logic signed [IW-1:0] data_in = '0;
    logic                clr_flags = 1'b0;
    logic                out_ready = 1'b0;
    logic signed [OW-1:0] data_out;
    logic                out_valid;
    logic [2:0]          level;
    logic                sat_flag;
    logic                drop_flag;

    cic_i_scaler #(.iw(IW), .ow(OW), .shift(SHIFT), .depth(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_dv     (in_dv),
        .data_in   (data_in),
        .clr_flags (clr_flags),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .level     (level),
        .sat_flag  (sat_flag),
        .drop_flag (drop_flag)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: input history of the last three edges, FIFO contents, flags.
    typedef struct { bit dv; int x; } hrec_t;
    hrec_t hq[$];
    int    mq[$];
    bit    m_sat = 1'b0;
    bit    m_drop = 1'b0;

    typedef struct {
        bit dv; int x; bit rdy; bit clr;
        bit ev; int ed; bit es; bit edrop;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Gain removal from the arithmetic rules: floor((x + half) / 2^shift), then clip.
    function automatic int scale(input int x, output bit clip);
        int d, t, q;
        d = 1 << SHIFT;
        t = x + ((SHIFT > 0) ? d / 2 : 0);
        q = (t >= 0) ? t / d : -((-t + d - 1) / d);
        clip = 1'b0;
        if (q > 127) begin q = 127; clip = 1'b1; end
        if (q < -128) begin q = -128; clip = 1'b1; end
        return q;
    endfunction

    task automatic model_edge();
        bit pop, push, clip, full, drop_ev;
        int val;
        if (!reset_n) begin
            hq.delete();
            mq.delete();
            m_sat  = 1'b0;
            m_drop = 1'b0;
        end else begin
            pop = (mq.size() > 0) && out_ready;
            hq.push_back('{in_dv, int'(data_in)});
            if (hq.size() > 3) void'(hq.pop_front());
            push = 1'b0; clip = 1'b0; val = 0;
            // A sample sampled two edges ago reaches the FIFO on this edge.
            if (hq.size() == 3 && hq[0].dv) begin
                val  = scale(hq[0].x, clip);
                push = 1'b1;
            end
            full    = (mq.size() == DEPTH);
            drop_ev = push && full && !pop;
            if (pop) void'(mq.pop_front());
            if (push && !drop_ev) mq.push_back(val);
            m_sat  = (push && clip) || (m_sat && !clr_flags);
            m_drop = drop_ev || (m_drop && !clr_flags);
        end
    endtask

    task automatic check_model();
        chk("level", int'(level), mq.size());
        chk("out_valid", int'(out_valid), int'(mq.size() > 0));
        if (mq.size() > 0) chk("data_out", int'(data_out), mq[0]);
        chk("sat_flag", int'(sat_flag), int'(m_sat));
        chk("drop_flag", int'(drop_flag), int'(m_drop));
    endtask

    task automatic step(input bit rst, input bit dv, input int x, input bit rdy, input bit clr);
        reset_n   = rst;
        in_dv     = dv;
        data_in   = IW'(x);
        out_ready = rdy;
        clr_flags = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        // Rounding rows 0-7, saturation/clear rows 8-17; out_ready held high.
        tbl[0]  = '{1, 64,    1, 0, 0, 0,    0, 0};
        tbl[1]  = '{1, 96,    1, 0, 0, 0,    0, 0};
        tbl[2]  = '{1, -96,   1, 0, 1, 1,    0, 0};
        tbl[3]  = '{1, 31,    1, 0, 1, 2,    0, 0};
        tbl[4]  = '{1, 32,    1, 0, 1, -1,   0, 0};
        tbl[5]  = '{0, 0,     1, 0, 1, 0,    0, 0};
        tbl[6]  = '{0, 0,     1, 0, 1, 1,    0, 0};
        tbl[7]  = '{0, 0,     1, 0, 0, 0,    0, 0};
        tbl[8]  = '{1, 8191,  1, 0, 0, 0,    0, 0};
        tbl[9]  = '{1, -8192, 1, 0, 0, 0,    0, 0};
        tbl[10] = '{0, 0,     1, 0, 1, 127,  1, 0};
        tbl[11] = '{0, 0,     1, 0, 1, -128, 1, 0};
        tbl[12] = '{0, 0,     1, 1, 0, 0,    0, 0};
        tbl[13] = '{1, 8191,  1, 0, 0, 0,    0, 0};
        tbl[14] = '{0, 0,     1, 0, 0, 0,    0, 0};
        tbl[15] = '{0, 0,     1, 1, 1, 127,  1, 0};
        tbl[16] = '{0, 0,     1, 0, 0, 0,    1, 0};
        tbl[17] = '{0, 0,     1, 1, 0, 0,    0, 0};

        // Reset state.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_level", int'(level), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_flags", int'({sat_flag, drop_flag}), 0);

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            step(1, tbl[i].dv, tbl[i].x, tbl[i].rdy, tbl[i].clr);
            chk("tbl_valid", int'(out_valid), int'(tbl[i].ev));
            if (tbl[i].ev) chk("tbl_data", int'(data_out), tbl[i].ed);
            chk("tbl_sat", int'(sat_flag), int'(tbl[i].es));
            chk("tbl_drop", int'(drop_flag), int'(tbl[i].edrop));
        end

        // Backpressure: eight samples into a four-deep FIFO with the consumer stalled.
        for (int k = 1; k <= 8; k++) step(1, 1, 64 * k, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
        chk("bp_level", int'(level), 4);
        chk("bp_drop", int'(drop_flag), 1);
        for (int k = 1; k <= 4; k++) begin
            chk("bp_order", int'(data_out), k);
            step(1, 0, 0, 1, 0);
        end
        chk("bp_empty_valid", int'(out_valid), 0);
        chk("bp_empty_level", int'(level), 0);
        step(1, 0, 0, 1, 1);
        chk("bp_drop_clr", int'(drop_flag), 0);

        // Full FIFO: the fifth sample lands on the same edge as a pop.
        for (int k = 1; k <= 5; k++) step(1, 1, 64 * k, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("ff_full", int'(level), 4);
        step(1, 0, 0, 1, 0);
        chk("ff_level", int'(level), 4);
        chk("ff_drop", int'(drop_flag), 0);
        chk("ff_head", int'(data_out), 2);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 1, 0);
        chk("ff_drained", int'(out_valid), 0);

        // Gapped input with random backpressure; pointers wrap several times.
        for (int k = 0; k < 40; k++)
            step(1, (k % 2) == 0, int'($urandom_range(0, 16383)) - 8192, 1'($urandom_range(0, 1)), 0);
        for (int k = 0; k < 8; k++) step(1, 0, 0, 1, 0);

        // Reset with three samples in the FIFO and two in the pipeline.
        for (int k = 1; k <= 5; k++) step(1, 1, 64 * k, 0, 0);
        chk("mr_pre_level", int'(level), 3);
        step(0, 1, 64, 0, 0);
        chk("mr_level", int'(level), 0);
        chk("mr_valid", int'(out_valid), 0);
        chk("mr_flags", int'({sat_flag, drop_flag}), 0);
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 0, 1, 0);
            chk("mr_no_ghost", int'(out_valid), 0);
        end

        // Randomized traffic over the full input range, occasional flag clears.
        for (int k = 0; k < 300; k++)
            step(1, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 16383)) - 8192,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
